// File: rtl/truth_table_sweeper_pkg.sv
// rtl/truth_table_sweeper_pkg.sv - shared types, defaults and priority encoder for the truth-table sweeper
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } sweep_state_t;

  localparam int DEF_N_IN     = 3;
  localparam int DEF_EVAL_LAT = 0;
  // Widest truth table the encoder handles (N_IN up to 6).
  localparam int MAX_VEC_W    = 64;

  // Lowest set bit index; 0 when the vector is empty.
  function automatic int first_set_index(input logic [MAX_VEC_W-1:0] vec);
    int result;
    result = 0;
    for (int i = MAX_VEC_W - 1; i >= 0; i--) begin
      if (vec[i]) result = i;
    end
    return result;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_vector_counter.sv
// rtl/truth_table_sweeper_vector_counter.sv - sweep index and per-vector latency counter
module sweep_vector_counter #(
  parameter int N_IN     = 3,
  parameter int EVAL_LAT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            en,
  output logic [N_IN-1:0] idx,
  output logic            capture_en,
  output logic            last_vector
);

  localparam int CW = (EVAL_LAT > 0) ? $clog2(EVAL_LAT + 1) : 1;

  logic [CW-1:0] cnt;
  logic          cnt_at_end;

  assign cnt_at_end  = (cnt == CW'(EVAL_LAT));
  assign capture_en  = en & cnt_at_end;
  // Terminal compare stops the sweep; idx parks on the last vector instead of wrapping.
  assign last_vector = (idx == {N_IN{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      cnt <= '0;
    end else if (clear) begin
      idx <= '0;
      cnt <= '0;
    end else if (en) begin
      if (cnt_at_end) begin
        cnt <= '0;
        if (!last_vector) idx <= idx + N_IN'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps all input vectors of an external function and checks its truth table
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN     = DEF_N_IN,
  parameter int EVAL_LAT = DEF_EVAL_LAT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [(1<<N_IN)-1:0] exp_mask,
  output logic [N_IN-1:0]      abc,
  output logic                 abc_valid,
  input  logic                 y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [(1<<N_IN)-1:0] tt,
  output logic [(1<<N_IN)-1:0] mismatch,
  output logic                 fail_valid,
  output logic [N_IN-1:0]      first_fail
);

  localparam int VEC_W = 1 << N_IN;

  sweep_state_t         state;
  logic [VEC_W-1:0]     exp_q;
  logic [VEC_W-1:0]     mism_next;
  logic [MAX_VEC_W-1:0] mism_ext;
  logic [N_IN-1:0]      idx;
  logic                 capture_en;
  logic                 last_vector;
  logic                 accept;
  logic                 abort_run;

  assign accept    = (state == IDLE) && start && !abort;
  assign abort_run = abort && ((state == DRIVE) || (state == CHECK));
  assign mism_next = tt ^ exp_q;
  assign mism_ext  = MAX_VEC_W'(mism_next);

  assign abc       = (state == DRIVE) ? idx : '0;
  assign abc_valid = (state == DRIVE);
  assign busy      = (state != IDLE);

  sweep_vector_counter #(
    .N_IN     (N_IN),
    .EVAL_LAT (EVAL_LAT)
  ) u_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (accept | abort_run),
    .en          (state == DRIVE),
    .idx         (idx),
    .capture_en  (capture_en),
    .last_vector (last_vector)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      exp_q      <= '0;
      tt         <= '0;
      mismatch   <= '0;
      pass       <= 1'b0;
      fail_valid <= 1'b0;
      first_fail <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_run) begin
        state      <= IDLE;
        tt         <= '0;
        mismatch   <= '0;
        pass       <= 1'b0;
        fail_valid <= 1'b0;
        first_fail <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              exp_q <= exp_mask;
              tt    <= '0;
              state <= DRIVE;
            end
          end
          DRIVE: begin
            if (capture_en) begin
              tt[idx] <= y;
              if (last_vector) state <= CHECK;
            end
          end
          CHECK: begin
            mismatch   <= mism_next;
            pass       <= (mism_next == '0);
            fail_valid <= |mism_next;
            first_fail <= N_IN'(first_set_index(mism_ext));
            state      <= DONE;
          end
          DONE: begin
            // done is registered here so it lands in IDLE, after results settled in CHECK.
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
